// File: rtl/io_pkg.sv
// Shared definitions for IO peripherals on the raisin64 64-bit IO bus:
// register offsets for the GPIO bank and the bus handshake state encoding.
package io_pkg;

    localparam logic [7:0] GPIO_OUT       = 8'h00;
    localparam logic [7:0] GPIO_IN        = 8'h08;
    localparam logic [7:0] GPIO_EDGE_STAT = 8'h10;
    localparam logic [7:0] GPIO_IRQ_MASK  = 8'h18;
    localparam logic [7:0] GPIO_EDGE_POL  = 8'h20;
    localparam logic [7:0] GPIO_OUT_SET   = 8'h28;
    localparam logic [7:0] GPIO_OUT_CLR   = 8'h30;

    // One-wait-state handshake: accept in IDLE, signal completion in RESP.
    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_RESP = 1'b1
    } bus_state_t;

endpackage

// File: rtl/io_sync_edge.sv
// Input synchroniser with per-bit, polarity-selectable edge event generation.
// Events are suppressed until the chain and prev register hold real samples,
// so inputs already high when reset is released do not look like edges.
module io_sync_edge #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    input  logic [WIDTH-1:0] pol,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] events
);

    localparam int PRIME = STAGES + 1;
    localparam int CNT_W = $clog2(PRIME + 1);

    logic [WIDTH-1:0] chain [STAGES];
    logic [WIDTH-1:0] prev;
    logic [CNT_W-1:0] prime_cnt;
    logic             primed;

    assign sync_out = chain[STAGES-1];
    assign primed   = (prime_cnt == CNT_W'(PRIME));

    // Shift the asynchronous inputs through the synchroniser flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= async_in;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    // Remember last cycle's synchronised value and count up to the primed state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev      <= '0;
            prime_cnt <= '0;
        end else begin
            prev <= sync_out;
            if (!primed) begin
                prime_cnt <= prime_cnt + CNT_W'(1);
            end
        end
    end

    // Rising edges where pol=0, falling edges where pol=1, gated by priming.
    always_comb begin
        events = '0;
        if (primed) begin
            events = (~pol & sync_out & ~prev) | (pol & ~sync_out & prev);
        end
    end

endmodule

// File: rtl/io_gpio_bank.sv
// Memory-mapped GPIO bank: output register with set/clear aliases, synchronised
// inputs, sticky edge status with W1C clear and a maskable level interrupt.
module io_gpio_bank
    import io_pkg::*;
#(
    parameter int OUT_W       = 16,
    parameter int IN_W        = 16,
    parameter int SYNC_STAGES = 2,
    parameter int OFS_W       = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bus_sel,
    input  logic             bus_valid,
    input  logic             bus_write,
    input  logic [OFS_W-1:0] bus_ofs,
    input  logic [63:0]      bus_wdata,
    output logic [63:0]      bus_rdata,
    output logic             bus_ready,
    input  logic [IN_W-1:0]  gpio_in,
    output logic [OUT_W-1:0] gpio_out,
    output logic             irq
);

    bus_state_t       state;
    bus_state_t       next_state;
    logic             accept;
    logic             wr_en;
    logic             rd_en;
    logic [OFS_W-1:0] reg_ofs;
    logic             sel_out, sel_in, sel_stat, sel_mask, sel_pol, sel_set, sel_clr;

    logic [OUT_W-1:0] out_reg;
    logic [IN_W-1:0]  in_sync;
    logic [IN_W-1:0]  edge_stat;
    logic [IN_W-1:0]  irq_mask;
    logic [IN_W-1:0]  edge_pol;
    logic [IN_W-1:0]  events;
    logic [IN_W-1:0]  stat_clr;
    logic [63:0]      read_data;

    io_sync_edge #(
        .WIDTH  (IN_W),
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (gpio_in),
        .pol      (edge_pol),
        .sync_out (in_sync),
        .events   (events)
    );

    assign reg_ofs  = {bus_ofs[OFS_W-1:3], 3'b000};
    assign sel_out  = (reg_ofs == OFS_W'(GPIO_OUT));
    assign sel_in   = (reg_ofs == OFS_W'(GPIO_IN));
    assign sel_stat = (reg_ofs == OFS_W'(GPIO_EDGE_STAT));
    assign sel_mask = (reg_ofs == OFS_W'(GPIO_IRQ_MASK));
    assign sel_pol  = (reg_ofs == OFS_W'(GPIO_EDGE_POL));
    assign sel_set  = (reg_ofs == OFS_W'(GPIO_OUT_SET));
    assign sel_clr  = (reg_ofs == OFS_W'(GPIO_OUT_CLR));

    assign accept   = (state == BUS_IDLE) && bus_sel && bus_valid;
    assign wr_en    = accept && bus_write;
    assign rd_en    = accept && !bus_write;
    assign gpio_out = out_reg;

    // Handshake state register; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BUS_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and ready: RESP lasts exactly one cycle before returning to IDLE.
    always_comb begin
        next_state = state;
        bus_ready  = 1'b0;
        case (state)
            BUS_IDLE: begin
                if (accept) begin
                    next_state = BUS_RESP;
                end
            end
            BUS_RESP: begin
                bus_ready  = 1'b1;
                next_state = BUS_IDLE;
            end
            default: next_state = BUS_IDLE;
        endcase
    end

    // Read mux; write-only and unmapped offsets return zero.
    always_comb begin
        read_data = '0;
        if (sel_out) begin
            read_data = 64'(out_reg);
        end else if (sel_in) begin
            read_data = 64'(in_sync);
        end else if (sel_stat) begin
            read_data = 64'(edge_stat);
        end else if (sel_mask) begin
            read_data = 64'(irq_mask);
        end else if (sel_pol) begin
            read_data = 64'(edge_pol);
        end
    end

    // Bits written as 1 to the status register are cleared this cycle.
    always_comb begin
        stat_clr = '0;
        if (wr_en && sel_stat) begin
            stat_clr = bus_wdata[IN_W-1:0];
        end
    end

    // Register writes take effect on the accept edge; reads are captured there too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg   <= '0;
            irq_mask  <= '0;
            edge_pol  <= '0;
            bus_rdata <= '0;
        end else begin
            if (wr_en) begin
                if (sel_out) begin
                    out_reg <= bus_wdata[OUT_W-1:0];
                end else if (sel_set) begin
                    out_reg <= out_reg | bus_wdata[OUT_W-1:0];
                end else if (sel_clr) begin
                    out_reg <= out_reg & ~bus_wdata[OUT_W-1:0];
                end else if (sel_mask) begin
                    irq_mask <= bus_wdata[IN_W-1:0];
                end else if (sel_pol) begin
                    edge_pol <= bus_wdata[IN_W-1:0];
                end
            end
            if (rd_en) begin
                bus_rdata <= read_data;
            end
        end
    end

    // Sticky edge status (a new event beats a simultaneous clear) and registered irq.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_stat <= '0;
            irq       <= 1'b0;
        end else begin
            edge_stat <= (edge_stat & ~stat_clr) | events;
            irq       <= |(edge_stat & irq_mask);
        end
    end

endmodule

// File: tb/tb_io_gpio_bank.sv
// Directed self-checking bench for io_gpio_bank with default parameters
// (16-bit ports, two synchroniser stages).
module tb_io_gpio_bank;

    logic        clk;
    logic        rst_n;
    logic        bus_sel;
    logic        bus_valid;
    logic        bus_write;
    logic [5:0]  bus_ofs;
    logic [63:0] bus_wdata;
    logic [63:0] bus_rdata;
    logic        bus_ready;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic        irq;

    int compared   = 0;
    int mismatched = 0;

    io_gpio_bank dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_sel   (bus_sel),
        .bus_valid (bus_valid),
        .bus_write (bus_write),
        .bus_ofs   (bus_ofs),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] value);
        gpio_in = value;
    endtask

    task automatic busWrite(input logic [5:0] ofs, input logic [63:0] data);
        bus_sel   = 1'b1;
        bus_valid = 1'b1;
        bus_write = 1'b1;
        bus_ofs   = ofs;
        bus_wdata = data;
        tick();
        checkOutput("write_ready", {63'd0, bus_ready}, 64'd1);
        bus_sel   = 1'b0;
        bus_valid = 1'b0;
        bus_write = 1'b0;
        tick();
        checkOutput("write_ready_drop", {63'd0, bus_ready}, 64'd0);
    endtask

    task automatic busRead(input logic [5:0] ofs, output logic [63:0] data);
        bus_sel   = 1'b1;
        bus_valid = 1'b1;
        bus_write = 1'b0;
        bus_ofs   = ofs;
        tick();
        checkOutput("read_ready", {63'd0, bus_ready}, 64'd1);
        data      = bus_rdata;
        bus_sel   = 1'b0;
        bus_valid = 1'b0;
        tick();
    endtask

    initial begin
        logic [63:0] rd;
        logic [5:0]  readyPattern;

        bus_sel   = 1'b0;
        bus_valid = 1'b0;
        bus_write = 1'b0;
        bus_ofs   = '0;
        bus_wdata = '0;
        rst_n     = 1'b0;
        applyStimulus(16'h1234);

        // Reset state
        #12;
        checkOutput("rst_gpio_out", 64'(gpio_out), 64'd0);
        checkOutput("rst_ready", {63'd0, bus_ready}, 64'd0);
        checkOutput("rst_irq", {63'd0, irq}, 64'd0);
        checkOutput("rst_rdata", bus_rdata, 64'd0);
        tick();
        rst_n = 1'b1;

        // Input latency: accept at edge 2 sees an unfilled chain, edge 4 sees the input
        tick();
        busRead(6'h08, rd);
        checkOutput("in_before_sync", rd, 64'd0);
        busRead(6'h08, rd);
        checkOutput("in_after_sync", rd, 64'h1234);
        busRead(6'h10, rd);
        checkOutput("no_false_edge", rd, 64'd0);
        checkOutput("no_false_irq", {63'd0, irq}, 64'd0);

        // Output register and its set/clear aliases
        busWrite(6'h00, 64'hBEEF);
        checkOutput("out_write", 64'(gpio_out), 64'hBEEF);
        busWrite(6'h28, 64'h0010);
        checkOutput("out_set", 64'(gpio_out), 64'hBEFF);
        busWrite(6'h30, 64'h00FF);
        checkOutput("out_clr", 64'(gpio_out), 64'hBE00);
        busRead(6'h28, rd);
        checkOutput("read_out_set_zero", rd, 64'd0);
        busRead(6'h00, rd);
        checkOutput("read_after_write", rd, 64'hBE00);

        // Rising edge on bit 0: status at SYNC_STAGES+1 edges, irq one edge later
        busWrite(6'h18, 64'h0001);
        busWrite(6'h20, 64'h0000);
        applyStimulus(16'h1235);
        tick();
        checkOutput("irq_e1", {63'd0, irq}, 64'd0);
        tick();
        checkOutput("irq_e2", {63'd0, irq}, 64'd0);
        tick();
        checkOutput("irq_e3", {63'd0, irq}, 64'd0);
        tick();
        checkOutput("irq_e4", {63'd0, irq}, 64'd1);
        busRead(6'h10, rd);
        checkOutput("stat_rise", rd, 64'h0001);
        busWrite(6'h10, 64'h0001);
        checkOutput("irq_after_w1c", {63'd0, irq}, 64'd0);
        busRead(6'h10, rd);
        checkOutput("stat_after_w1c", rd, 64'd0);

        // Falling polarity on bit 1
        busWrite(6'h20, 64'h0002);
        busRead(6'h20, rd);
        checkOutput("pol_readback", rd, 64'h0002);
        applyStimulus(16'h1237);
        repeat (4) tick();
        busRead(6'h10, rd);
        checkOutput("pol_rise_ignored", rd, 64'd0);
        applyStimulus(16'h1235);
        repeat (4) tick();
        busRead(6'h10, rd);
        checkOutput("pol_fall_event", rd, 64'h0002);
        checkOutput("masked_no_irq", {63'd0, irq}, 64'd0);
        applyStimulus(16'h1237);
        repeat (4) tick();
        applyStimulus(16'h1235);
        repeat (4) tick();
        busRead(6'h10, rd);
        checkOutput("sticky_second_edge", rd, 64'h0002);

        // W1C colliding with a new bit 0 event: set wins, bit 1 clears
        applyStimulus(16'h1234);
        repeat (4) tick();
        applyStimulus(16'h1235);
        tick();
        tick();
        busWrite(6'h10, 64'h0003);
        busRead(6'h10, rd);
        checkOutput("set_beats_clear", rd, 64'h0001);

        // Back-to-back reads with valid held high
        bus_sel   = 1'b1;
        bus_valid = 1'b1;
        bus_write = 1'b0;
        bus_ofs   = 6'h08;
        for (int i = 0; i < 6; i++) begin
            tick();
            readyPattern[i] = bus_ready;
        end
        bus_sel   = 1'b0;
        bus_valid = 1'b0;
        checkOutput("ready_pattern", 64'(readyPattern), 64'h15);
        checkOutput("held_read_data", bus_rdata, 64'h1235);
        tick();
        checkOutput("rdata_hold", bus_rdata, 64'h1235);
        busRead(6'h38, rd);
        checkOutput("unmapped_read", rd, 64'd0);
        busWrite(6'h38, 64'hFFFF);
        checkOutput("unmapped_write_ignored", 64'(gpio_out), 64'hBE00);

        // Reset asserted during RESP
        bus_sel   = 1'b1;
        bus_valid = 1'b1;
        bus_write = 1'b1;
        bus_ofs   = 6'h00;
        bus_wdata = 64'hAAAA;
        tick();
        checkOutput("pre_reset_ready", {63'd0, bus_ready}, 64'd1);
        checkOutput("pre_reset_out", 64'(gpio_out), 64'hAAAA);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_ready", {63'd0, bus_ready}, 64'd0);
        checkOutput("reset_out", 64'(gpio_out), 64'd0);
        checkOutput("reset_irq", {63'd0, irq}, 64'd0);
        checkOutput("reset_rdata", bus_rdata, 64'd0);
        bus_sel   = 1'b0;
        bus_valid = 1'b0;
        bus_write = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
